// File: rtl/masked_state_sel_reg.sv
// Registered shared-state selector for a round-based masked PRINCE core: loads fresh shares, then iterates
// the external round function ROUNDS times under an internal FSM. Optional output gating: MASKED_STATE_OUT_GATE_EN.
module masked_state_sel_reg #(
    parameter int WIDTH  = 64,
    parameter int SHARES = 5,
    parameter int ROUNDS = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SHARES*WIDTH-1:0]   in_data,
    input  logic [SHARES*WIDTH-1:0]   round_data,
    output logic [SHARES*WIDTH-1:0]   state,
    output logic [7:0]                round_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

    fsm_t fsm;
    logic load_sel;
    logic state_we;
    logic final_upd;
    logic out_ack;
    logic [SHARES*WIDTH-1:0] state_int;

    // One select signal and one write enable, fanned out unchanged to every share bank.
    assign load_sel  = (fsm == IDLE) && in_valid;
    assign state_we  = load_sel || (fsm == RUN);
    assign final_upd = (fsm == RUN) && (round_idx == LAST_IDX);
    assign out_ack   = (fsm == DONE) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            round_idx <= 8'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        fsm       <= RUN;
                        round_idx <= 8'd0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    round_idx <= round_idx + 8'd1;
                    if (round_idx == LAST_IDX) begin
                        fsm       <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < SHARES; i++) begin : g_share
        logic [WIDTH-1:0] state_bank;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_bank <= '0;
            end else if (state_we) begin
                state_bank <= load_sel ? in_data[i*WIDTH +: WIDTH] : round_data[i*WIDTH +: WIDTH];
            end
        end

        assign state_int[i*WIDTH +: WIDTH] = state_bank;

`ifdef MASKED_STATE_OUT_GATE_EN
        // Port bank only ever holds the final state, so intermediate rounds never leave the block.
        logic [WIDTH-1:0] gate_bank;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                gate_bank <= '0;
            end else if (final_upd) begin
                gate_bank <= round_data[i*WIDTH +: WIDTH];
            end else if (out_ack) begin
                gate_bank <= '0;
            end
        end

        assign state[i*WIDTH +: WIDTH] = gate_bank;
`else
        assign state[i*WIDTH +: WIDTH] = state_int[i*WIDTH +: WIDTH];
`endif
    end

`ifndef MASKED_STATE_OUT_GATE_EN
    logic unused_ctl;
    assign unused_ctl = final_upd ^ out_ack;
`endif

endmodule

// File: tb/tb_masked_state_sel_reg.sv
// Directed self-checking bench for masked_state_sel_reg (WIDTH=64, SHARES=5, ROUNDS=12).
module tb_masked_state_sel_reg;

    localparam int W  = 64;
    localparam int S  = 5;
    localparam int R  = 12;
    localparam int SW = S * W;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_data;
    logic [SW-1:0] round_data;
    logic [SW-1:0] state;
    logic [7:0]    round_idx;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          rf_inc;

    int checks = 0;
    int errors = 0;

    masked_state_sel_reg #(.WIDTH(W), .SHARES(S), .ROUNDS(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .round_data(round_data),
        .state     (state),
        .round_idx (round_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External round function: per-share +1 (rf_inc=1) or identity (rf_inc=0).
    always_comb begin
        round_data = '0;
        for (int i = 0; i < S; i++) begin
`ifdef MASKED_STATE_OUT_GATE_EN
            round_data[i*W +: W] = dut.state_int[i*W +: W] + W'(rf_inc);
`else
            round_data[i*W +: W] = state[i*W +: W] + W'(rf_inc);
`endif
        end
    end

    // Expected shared state after n round updates of +k from value v.
    function automatic logic [SW-1:0] add_all(input logic [SW-1:0] v, input int n);
        logic [SW-1:0] r;
        for (int i = 0; i < S; i++) r[i*W +: W] = v[i*W +: W] + W'(n);
        return r;
    endfunction

    // What the state port should show given the expected internal value and out_valid.
    function automatic logic [SW-1:0] vis(input logic [SW-1:0] v, input logic ov);
`ifdef MASKED_STATE_OUT_GATE_EN
        return ov ? v : '0;
`else
        return v;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            for (int j = 0; j < SW / 32; j++) in_data[j*32 +: 32] = $urandom;
        end
        checks++; if (state !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", state); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (round_idx !== 8'd0) begin errors++; $display("FAIL reset_round_idx: got %0d expected 0", round_idx); end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: got in_ready=%b busy=%b expected 1 0", in_ready, busy); end
    endtask

    task automatic test_basic();
        logic [SW-1:0] init;
        logic [SW-1:0] fin;
        init = '0;
        init[W-1:0] = 64'h0123456789ABCDEF;
        fin = add_all(init, R);
        rf_inc = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        in_data   = init;
        in_valid  = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (n == 1) begin
                checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_run_flags: got busy=%b in_ready=%b expected 1 0", busy, in_ready); end
                checks++; if (state !== vis(init, 1'b0)) begin errors++; $display("FAIL basic_loaded: got %h expected %h", state, vis(init, 1'b0)); end
            end
            if (n == 7) begin
                checks++; if (round_idx !== 8'd6 || state !== vis(add_all(init, 6), 1'b0)) begin errors++; $display("FAIL basic_mid: got idx=%0d state=%h expected 6 %h", round_idx, state, vis(add_all(init, 6), 1'b0)); end
            end
            if (n == 12) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
            end
            if (n == 13) begin
                checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_out_valid: got out_valid=%b busy=%b expected 1 0", out_valid, busy); end
                checks++; if (state[W-1:0] !== 64'h0123456789ABCDFB) begin errors++; $display("FAIL basic_share0: got %h expected 0123456789abcdfb", state[W-1:0]); end
                checks++; if (state !== fin) begin errors++; $display("FAIL basic_final: got %h expected %h", state, fin); end
                checks++; if (round_idx !== 8'd12) begin errors++; $display("FAIL basic_round_idx: got %0d expected 12", round_idx); end
            end
            if (n == 14) begin
                checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
                checks++; if (round_idx !== 8'd12 || state !== vis(fin, 1'b0)) begin errors++; $display("FAIL basic_idle_hold: got idx=%0d state=%h expected 12 %h", round_idx, state, vis(fin, 1'b0)); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] init;
        logic [SW-1:0] fin;
        for (int i = 0; i < S; i++) init[i*W +: W] = W'(64'h1000 * (i + 1));
        fin = add_all(init, R);
        rf_inc = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_data   = init;
        in_valid  = 1'b1;
        repeat (13) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            for (int j = 0; j < SW / 32; j++) in_data[j*32 +: 32] = $urandom;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_flags_%0d: got out_valid=%b in_ready=%b expected 1 0", c, out_valid, in_ready); end
            checks++; if (state !== fin || round_idx !== 8'd12) begin errors++; $display("FAIL bp_hold_%0d: got idx=%0d state=%h expected 12 %h", c, round_idx, state, fin); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
        checks++; if (state !== vis(fin, 1'b0)) begin errors++; $display("FAIL bp_release_state: got %h expected %h", state, vis(fin, 1'b0)); end
    endtask

    task automatic test_midrun_reset();
        logic [SW-1:0] init;
        logic [SW-1:0] init2;
        for (int i = 0; i < S; i++) init[i*W +: W]  = W'(64'hA5A5_0000_0000_0000 + 64'(i));
        for (int i = 0; i < S; i++) init2[i*W +: W] = W'(64'h0000_1111_2222_3330 + 64'(i * 16));
        rf_inc = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        in_data   = init;
        in_valid  = 1'b1;
        repeat (7) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        checks++; if (round_idx !== 8'd6 || state !== vis(add_all(init, 6), 1'b0)) begin errors++; $display("FAIL mid_pre_reset: got idx=%0d state=%h expected 6 %h", round_idx, state, vis(add_all(init, 6), 1'b0)); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (state !== '0 || round_idx !== 8'd0) begin errors++; $display("FAIL mid_async_clear: got idx=%0d state=%h expected 0 0", round_idx, state); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_flags: got busy=%b in_ready=%b out_valid=%b expected 0 1 0", busy, in_ready, out_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_spurious: got out_valid=%b busy=%b expected 0 0", out_valid, busy); end
        in_data  = init2;
        in_valid = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (n == 12) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reload_early: got %b expected 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1 || state !== add_all(init2, R)) begin errors++; $display("FAIL mid_reload_final: got out_valid=%b state=%h expected 1 %h", out_valid, state, add_all(init2, R)); end
        @(negedge clk);
    endtask

    task automatic test_share_isolation();
        logic [SW-1:0] init;
        logic          ov_exp;
        rf_inc    = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < S; k++) begin
            init = '0;
            init[k*W +: W] = {W{1'b1}};
            @(negedge clk);
            in_data  = init;
            in_valid = 1'b1;
            for (int n = 1; n <= 14; n++) begin
                @(negedge clk);
                in_valid = 1'b0;
                ov_exp   = (n == 13);
                checks++; if (state !== vis(init, ov_exp) || out_valid !== ov_exp) begin errors++; $display("FAIL iso_k%0d_n%0d: got out_valid=%b state=%h expected %b %h", k, n, out_valid, state, ov_exp, vis(init, ov_exp)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] d1;
        logic [SW-1:0] d2;
        for (int i = 0; i < S; i++) d1[i*W +: W] = W'(64'h0F0F_0F0F_0000_0000 + 64'(i));
        for (int i = 0; i < S; i++) d2[i*W +: W] = W'(64'hF0F0_F0F0_0000_0100 + 64'(i));
        rf_inc    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_data  = d1;
        in_valid = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            in_data = d2;
            if (n == 13) begin
                checks++; if (out_valid !== 1'b1 || state !== add_all(d1, R)) begin errors++; $display("FAIL b2b_first_done: got out_valid=%b state=%h expected 1 %h", out_valid, state, add_all(d1, R)); end
            end
            if (n == 14) begin
                checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || state !== vis(add_all(d1, R), 1'b0)) begin errors++; $display("FAIL b2b_gap: got in_ready=%b busy=%b state=%h expected 1 0 %h", in_ready, busy, state, vis(add_all(d1, R), 1'b0)); end
            end
            if (n == 15) begin
                checks++; if (busy !== 1'b1 || round_idx !== 8'd0 || state !== vis(d2, 1'b0)) begin errors++; $display("FAIL b2b_second_load: got busy=%b idx=%0d state=%h expected 1 0 %h", busy, round_idx, state, vis(d2, 1'b0)); end
            end
        end
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        checks++; if (in_ready !== 1'b1 || round_idx !== 8'd12) begin errors++; $display("FAIL b2b_drain: got in_ready=%b idx=%0d expected 1 12", in_ready, round_idx); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        rf_inc    = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_midrun_reset();
        test_share_isolation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
